// File: rtl/mem_bus_arbiter.sv
// Shares the single memory bus between the CPU controlpath and a debug/loader port.
// Each access holds the bus for WAIT_STATES+1 cycles; contention alternates between owners.
module mem_bus_arbiter #(
    parameter int WAIT_STATES = 1,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_DBG = 1'b1;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant_dbg;

    // DBG wins when it asks alone, or when both ask and the CPU had the bus last.
    assign grant_dbg = dbg_req & (~cpu_req | (last_owner_q == OWN_CPU));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    cnt_d   = WS_INIT;
                    state_d = ACCESS;
                    if (grant_dbg) begin
                        owner_d = OWN_DBG;
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end else begin
                        owner_d = OWN_CPU;
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Read data is captured even if the requester has since withdrawn.
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) begin
                            dbg_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    last_owner_d = owner_q;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DBG;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 4'd0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = (state_q == ACCESS) & ~we_q;
    assign mem_we    = (state_q == ACCESS) & we_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign dbg_ack   = (state_q == DONE) & (owner_q == OWN_DBG);
    // Stall covers the request cycle itself and releases only in the CPU's DONE cycle.
    assign cpu_stall = cpu_req & ~((state_q == DONE) & (owner_q == OWN_CPU));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic, all checked
// against a transaction-level timing model driven by grant timestamps.
module tb_mem_bus_arbiter;
    localparam int WS = 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, dbg_ack, mem_re, mem_we;

    // Memory behind the bus plus a load port used to preload it.
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] ram [256];

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(.WAIT_STATES(WS), .AW(16), .DW(16)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clock = ~clock;

    assign mem_rdata = ram[mem_addr[7:0]];

    initial forever begin
        @(clock);
        if (clock && ld_en) ram[ld_addr] = ld_data;
        if (!clock && mem_we) ram[mem_addr[7:0]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction described by its grant edge.
    // ACCESS occupies periods start..start+WS, DONE is start+WS+1, bus free after.
    logic [15:0] mdl_mem [256];
    int unsigned cyc = 0;
    int unsigned m_start = 0;
    bit          m_valid = 0;
    bit          m_busy = 0;
    bit          m_owner = 0;  // 1 = debug port
    bit          m_last = 1;
    bit          m_we = 0;
    logic [15:0] m_addr = 0, m_wdata = 0, m_cpu_rd = 0, m_dbg_rd = 0;

    task automatic model_step();
        int unsigned ce;
        if (ld_en) mdl_mem[ld_addr] = ld_data;
        if (m_busy && cyc >= m_start && cyc <= m_start + WS && m_we)
            mdl_mem[m_addr[7:0]] = m_wdata;
        ce = cyc + 1;
        if (reset) begin
            m_valid  = 1;
            m_busy   = 0;
            m_last   = 1;
            m_cpu_rd = 0;
            m_dbg_rd = 0;
        end else if (m_valid) begin
            if (m_busy) begin
                if (ce == m_start + WS + 1) begin
                    if (!m_we) begin
                        if (m_owner) m_dbg_rd = mdl_mem[m_addr[7:0]];
                        else         m_cpu_rd = mdl_mem[m_addr[7:0]];
                    end
                    m_last = m_owner;
                end
                if (ce == m_start + WS + 2) m_busy = 0;
            end else if (cpu_req || dbg_req) begin
                m_owner = (cpu_req && dbg_req) ? !m_last : dbg_req;
                m_we    = m_owner ? dbg_we : cpu_we;
                m_addr  = m_owner ? dbg_addr : cpu_addr;
                m_wdata = m_owner ? dbg_wdata : cpu_wdata;
                m_start = ce;
                m_busy  = 1;
            end
        end
        cyc = ce;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    initial forever begin
        bit acc, done;
        @(negedge clock);
        if (m_valid) begin
            acc  = m_busy && cyc >= m_start && cyc <= m_start + WS;
            done = m_busy && cyc == m_start + WS + 1;
            chk("mem_re", 32'(mem_re), 32'(acc && !m_we));
            chk("mem_we", 32'(mem_we), 32'(acc && m_we));
            if (acc) begin
                chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
            end
            chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !(done && !m_owner)));
            chk("dbg_ack", 32'(dbg_ack), 32'(done && m_owner));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(m_cpu_rd));
            chk("dbg_rdata", 32'(dbg_rdata), 32'(m_dbg_rd));
        end
    end

    // Release each requester once it is served; a bounded wait counts as a check.
    task automatic drain();
        bit ok, cd, dd;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            cd = cpu_req && !cpu_stall;
            dd = dbg_ack;
            @(posedge clock); #1;
            if (cd) cpu_req = 0;
            if (dd) dbg_req = 0;
            if (!cpu_req && !dbg_req) begin
                ok = 1;
                break;
            end
        end
        chk("drain", 32'(ok), 32'd1);
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        int          k, nre, nwe, nack, n;
        logic [15:0] seq [4];
        int          st [4];
        logic [15:0] saved, first_addr;
        bit          prev, got_ack, c_done, d_done;

        reset = 1; ld_en = 1; ld_addr = 0; ld_data = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            ld_addr = 8'(i);
            ld_data = (i == 16) ? 16'h1234 : (i == 48) ? 16'h00AA : 16'($urandom);
            @(posedge clock); #1;
        end
        ld_en = 0;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_dbg_rdata", 32'(dbg_rdata), 0);
        chk("rst_dbg_ack", 32'(dbg_ack), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);

        // Simultaneous requests after reset: CPU first, then strict alternation.
        @(posedge clock); #1;
        cpu_we = 0; cpu_addr = 16'h0020; dbg_we = 0; dbg_addr = 16'h0021;
        cpu_req = 1; dbg_req = 1;
        for (int i = 0; i < 4; i++) begin seq[i] = 16'hFFFF; st[i] = 0; end
        n = 0; prev = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clock);
            if (mem_re && !prev) begin seq[n] = mem_addr; st[n] = i; n++; end
            prev = mem_re;
        end
        chk("tie_grant0", 32'(seq[0]), 32'h0020);
        chk("tie_grant1", 32'(seq[1]), 32'h0021);
        chk("tie_grant2", 32'(seq[2]), 32'h0020);
        chk("tie_grant3", 32'(seq[3]), 32'h0021);
        chk("tie_spacing", 32'(st[1] - st[0]), 32'(WS + 3));
        @(posedge clock); #1;
        cpu_req = 0; dbg_req = 0;
        repeat (6) @(posedge clock);
        #1;

        // CPU read of 0x0010.
        cpu_we = 0; cpu_addr = 16'h0010; cpu_req = 1;
        k = 0; nre = 0;
        @(negedge clock);
        while (cpu_stall && k < 12) begin
            @(negedge clock);
            k++;
            if (mem_re) nre++;
        end
        chk("rd_stall_latency", 32'(k), 32'(WS + 2));
        chk("rd_re_cycles", 32'(nre), 32'(WS + 1));
        chk("rd_cpu_rdata", 32'(cpu_rdata), 32'h1234);
        @(posedge clock); #1;
        cpu_req = 0;
        repeat (2) @(posedge clock);
        #1;

        // Debug write 0x2000 <- 0xBEEF.
        saved = dbg_rdata;
        dbg_we = 1; dbg_addr = 16'h2000; dbg_wdata = 16'hBEEF; dbg_req = 1;
        nwe = 0; nack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_we && mem_addr == 16'h2000 && mem_wdata == 16'hBEEF) nwe++;
            if (dbg_ack) nack++;
            if (dbg_ack && dbg_req) begin @(posedge clock); #1; dbg_req = 0; end
        end
        chk("wr_we_cycles", 32'(nwe), 32'(WS + 1));
        chk("wr_ack_pulses", 32'(nack), 1);
        chk("wr_dbg_rdata_kept", 32'(dbg_rdata), 32'(saved));
        chk("wr_mem_content", 32'(ram[0]), 32'hBEEF);
        @(posedge clock); #1;

        // Debug withdraws mid-read; access still completes, pending CPU goes next.
        dbg_we = 0; dbg_addr = 16'h0030; dbg_req = 1;
        @(posedge clock); #1;
        cpu_we = 0; cpu_addr = 16'h0031; cpu_req = 1; dbg_req = 0;
        got_ack = 0;
        for (int i = 0; i < 12 && !got_ack; i++) begin
            @(negedge clock);
            got_ack = dbg_ack;
        end
        chk("drop_ack", 32'(got_ack), 1);
        chk("drop_dbg_rdata", 32'(dbg_rdata), 32'h00AA);
        first_addr = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mem_re) begin first_addr = mem_addr; break; end
        end
        chk("drop_next_grant", 32'(first_addr), 32'h0031);
        drain();

        // Reset during the second ACCESS cycle of a CPU write.
        cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h5555; cpu_req = 1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1;
        @(negedge clock);
        chk("rst_mid_we_before", 32'(mem_we), 1);
        @(posedge clock); #1;
        reset = 0;
        dbg_we = 0; dbg_addr = 16'h0041; dbg_req = 1;
        @(negedge clock);
        chk("rst_mid_we_after", 32'(mem_we), 0);
        chk("rst_mid_stall", 32'(cpu_stall), 1);
        chk("rst_mid_ack", 32'(dbg_ack), 0);
        first_addr = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mem_re || mem_we) begin first_addr = mem_addr; break; end
        end
        chk("rst_mid_tie_cpu", 32'(first_addr), 32'h0040);
        drain();

        // Randomized traffic: well-behaved requesters with occasional withdrawals and resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            c_done = cpu_req && !cpu_stall;
            d_done = dbg_ack;
            @(posedge clock); #1;
            reset = ($urandom_range(0, 299) == 0);
            if (cpu_req) begin
                if (c_done) cpu_req = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 49) == 0) cpu_req = 0;
            end else begin
                cpu_req = ($urandom_range(0, 2) == 0);
            end
            if (dbg_req) begin
                if (d_done) dbg_req = 0;
                else if ($urandom_range(0, 49) == 0) dbg_req = 0;
            end else begin
                dbg_req = ($urandom_range(0, 3) == 0);
            end
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom);
            cpu_wdata = 16'($urandom);
            dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = 16'($urandom);
            dbg_wdata = 16'($urandom);
        end
        reset = 0; cpu_req = 0; dbg_req = 0;
        repeat (8) @(posedge clock);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
